idle_time_monitor: RTL and testbench
====================================

IDLE_TIME_MONITOR -- requirements
Module: idle_time_monitor

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, number of probe channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 32, width of window, count, peak and threshold registers (8..32).
REQ-003 SHALL have parameter PROBE_INV, default all zeros (NUM_CH bits); bit n=1 counts channel n idle when iProbe[n]=0.
REQ-004 SHALL have port iClock, input, 1, the single clock.
REQ-005 SHALL have port iReset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port iWriteAddress, input, 32, register write address (bits 15:0 decoded).
REQ-007 SHALL have port iWriteData, input, 32, register write data.
REQ-008 SHALL have port iWriteValid, input, 1, write strobe.
REQ-009 SHALL have port oWriteAck, output, 1, constant 1.
REQ-010 SHALL have port iReadAddress, input, 32, register read address (bits 15:0 decoded).
REQ-011 SHALL have port oReadData, output, 32, read data, zero-extended from CNT_W.
REQ-012 SHALL have port iReadValid, input, 1, read request.
REQ-013 SHALL have port oReadAck, output, 1, read acknowledge.
REQ-014 SHALL have port iProbe, input, NUM_CH, per-channel idle indicators, synchronous to iClock.
REQ-015 SHALL have port oIrq, output, 1, level interrupt.

Function
REQ-016 Register map, channel n base = n*0x10: +0x0 PERIOD (RW); +0x4 LAST (RO); +0x8 PEAK (RO, any write clears); +0xC THRESH (RW).
REQ-017 Global registers: 0x100 CTRL bit0 = global enable (RW); 0x104 ALARM_STS, NUM_CH bits, sticky, write-1-to-clear; 0x108 ALARM_EN, NUM_CH bits (RW).
REQ-018 Unmapped or out-of-range channel reads SHALL return 0; writes to them SHALL be ignored.
REQ-019 Reads: when iReadValid=1 and oReadAck=0, oReadData SHALL update and oReadAck SHALL go high on the next edge for exactly one cycle; back-to-back requests get an ack every second cycle.
REQ-020 Writes SHALL take effect on the edge where iWriteValid=1.
REQ-021 Channel active = CTRL.enable=1 and PERIOD!=0; an inactive channel holds its window counter and accumulator at 0.
REQ-022 Idle sample for channel n = iProbe[n] XOR PROBE_INV[n].
REQ-023 Active channel, each cycle: window counter increments; accumulator adds the idle sample, saturating at 2^CNT_W-1.
REQ-024 Window end, cycle where window counter = PERIOD-1: result = saturated accumulator plus current sample; LAST <= result; window counter and accumulator <= 0.
REQ-025 At window end: PEAK <= result if result > PEAK; ALARM_STS[n] set if result > THRESH.
REQ-026 Writing PERIOD SHALL zero window counter and accumulator on the same edge and restart the window; LAST and PEAK are unchanged.
REQ-027 Clearing CTRL.enable mid-window SHALL discard the partial window.
REQ-028 On a simultaneous W1C and set of the same ALARM_STS bit, set SHALL win.
REQ-029 On a simultaneous PEAK clear and window end, PEAK SHALL load result.
REQ-030 oIrq SHALL be registered: oIrq <= |(ALARM_STS & ALARM_EN), one cycle after the status change.

Reset
REQ-031 iReset SHALL asynchronously clear all of the following to 0: PERIOD, THRESH, LAST, PEAK, window counters, accumulators, CTRL, ALARM_STS, ALARM_EN, oReadData, oReadAck, oIrq.
REQ-032 Reset asserted mid-window or mid-read SHALL abort the operation; no ack is issued after reset release without a new request.

Structure
REQ-033 Shared package SHALL hold: register offsets (0x0/0x4/0x8/0xC, 0x100/0x104/0x108), channel stride 0x10, max NUM_CH = 16.
REQ-034 Per-channel logic SHALL be sub-module idle_window_counter (CNT_W parameter; inputs: sample, active, period, restart; outputs: window-end pulse, result).
REQ-035 The top SHALL hold address decode, read mux, alarm, peak and interrupt logic.

Verification
REQ-036 PERIOD0=10, CTRL=1, iProbe[0]=1 constant -> LAST0=10 after 10 cycles; PEAK0=10.
REQ-037 PERIOD1=8, probe high for 3 cycles of the window, THRESH1=2, ALARM_EN=0x2 -> LAST1=3, ALARM_STS=0x2, oIrq=1 next cycle; W1C 0x2 -> oIrq=0.
REQ-038 CNT_W=8, PERIOD=0x1FF written via low 8 bits (=0xFF), probe constant 1 -> LAST=0xFF, no wrap.
REQ-039 PEAK clear written in the window-end cycle with result 5 -> PEAK=5; W1C coinciding with an alarm set -> bit stays 1.
REQ-040 PERIOD rewritten at cycle 4 of 10 -> next LAST appears 10 cycles after the write; iReset asserted mid-window -> every register reads 0.
REQ-041 Read 0x200 -> 0; iReadValid held high for 4 cycles -> oReadAck pattern 1,0,1,0.

Source files
------------

// File: rtl/idle_time_monitor_pkg.sv
// Shared register map constants for the idle-time monitor.
// Pure declarations; no latency or backpressure of its own.
package idle_time_monitor_pkg;

  localparam int MAX_CH = 16;

  localparam logic [15:0] CH_STRIDE = 16'h0010;
  localparam logic [15:0] CH_SPAN   = CH_STRIDE * 16'(MAX_CH);

  typedef enum logic [3:0] {
    OFF_PERIOD = 4'h0,
    OFF_LAST   = 4'h4,
    OFF_PEAK   = 4'h8,
    OFF_THRESH = 4'hC
  } ch_off_e;

  localparam logic [15:0] ADDR_CTRL      = 16'h0100;
  localparam logic [15:0] ADDR_ALARM_STS = 16'h0104;
  localparam logic [15:0] ADDR_ALARM_EN  = 16'h0108;

endpackage

// File: rtl/idle_window_counter.sv
// Per-channel idle window: counts idle samples over PERIOD cycles, result valid with win_end.
// Result is combinational in the window-end cycle; no backpressure, one sample per clock.
module idle_window_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample,
  input  logic             active,
  input  logic [CNT_W-1:0] period,
  input  logic             restart,
  output logic             win_end,
  output logic [CNT_W-1:0] result
);

  logic [CNT_W-1:0] win_cnt;
  logic [CNT_W-1:0] acc;
  logic [CNT_W:0]   sum;

  assign sum     = {1'b0, acc} + {{CNT_W{1'b0}}, sample};
  assign result  = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  // A PERIOD rewrite restarts the window, so it must not also close one.
  assign win_end = active && !restart && (win_cnt == period - CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt <= '0;
      acc     <= '0;
    end else if (!active || restart || win_end) begin
      win_cnt <= '0;
      acc     <= '0;
    end else begin
      win_cnt <= win_cnt + CNT_W'(1);
      acc     <= result;
    end
  end

endmodule

// File: rtl/idle_time_monitor.sv
// Idle-time monitor: per-channel windowed idle counts, peak/threshold alarms, level IRQ.
// Reads ack one cycle after request (every second cycle when held); writes always accepted.
module idle_time_monitor
  import idle_time_monitor_pkg::*;
#(
  parameter int                NUM_CH    = 8,
  parameter int                CNT_W     = 32,
  parameter logic [NUM_CH-1:0] PROBE_INV = '0
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic [31:0]       iWriteAddress,
  input  logic [31:0]       iWriteData,
  input  logic              iWriteValid,
  output logic              oWriteAck,
  input  logic [31:0]       iReadAddress,
  output logic [31:0]       oReadData,
  input  logic              iReadValid,
  output logic              oReadAck,
  input  logic [NUM_CH-1:0] iProbe,
  output logic              oIrq
);

  logic [15:0]      wa;
  logic [15:0]      ra;
  logic [CNT_W-1:0] wd;
  logic             ch_wr;
  logic             unused_bits;

  logic [NUM_CH-1:0][CNT_W-1:0] period_q;
  logic [NUM_CH-1:0][CNT_W-1:0] thresh_q;
  logic [NUM_CH-1:0][CNT_W-1:0] last_q;
  logic [NUM_CH-1:0][CNT_W-1:0] peak_q;
  logic [NUM_CH-1:0][CNT_W-1:0] res;

  logic              ctrl_en;
  logic [NUM_CH-1:0] alarm_sts;
  logic [NUM_CH-1:0] alarm_en;
  logic [NUM_CH-1:0] alarm_set;
  logic [NUM_CH-1:0] sts_clr;
  logic [NUM_CH-1:0] win_end;
  logic [NUM_CH-1:0] restart;
  logic [NUM_CH-1:0] peak_clr;
  logic [NUM_CH-1:0] active;
  logic [31:0]       rd_mux;

  assign wa          = iWriteAddress[15:0];
  assign ra          = iReadAddress[15:0];
  assign wd          = iWriteData[CNT_W-1:0];
  assign ch_wr       = iWriteValid && (wa < CH_SPAN);
  assign oWriteAck   = 1'b1;
  assign unused_bits = ^{iWriteAddress[31:16], iReadAddress[31:16], iWriteData};

  assign sts_clr = (iWriteValid && wa == ADDR_ALARM_STS) ? iWriteData[NUM_CH-1:0] : '0;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    assign active[n]    = ctrl_en && (period_q[n] != '0);
    assign restart[n]   = ch_wr && (wa[7:4] == 4'(n)) && (wa[3:0] == OFF_PERIOD);
    assign peak_clr[n]  = ch_wr && (wa[7:4] == 4'(n)) && (wa[3:0] == OFF_PEAK);
    assign alarm_set[n] = win_end[n] && (res[n] > thresh_q[n]);

    idle_window_counter #(.CNT_W(CNT_W)) u_win (
      .clk     (iClock),
      .rst     (iReset),
      .sample  (iProbe[n] ^ PROBE_INV[n]),
      .active  (active[n]),
      .period  (period_q[n]),
      .restart (restart[n]),
      .win_end (win_end[n]),
      .result  (res[n])
    );
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      period_q  <= '0;
      thresh_q  <= '0;
      last_q    <= '0;
      peak_q    <= '0;
      ctrl_en   <= 1'b0;
      alarm_sts <= '0;
      alarm_en  <= '0;
      oIrq      <= 1'b0;
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (ch_wr && wa[7:4] == 4'(n)) begin
          case (wa[3:0])
            OFF_PERIOD: period_q[n] <= wd;
            OFF_THRESH: thresh_q[n] <= wd;
            default: ;
          endcase
        end
        if (win_end[n]) begin
          last_q[n] <= res[n];
        end
        // A clear landing on the window-end edge still records that window.
        if (win_end[n] && (peak_clr[n] || res[n] > peak_q[n])) begin
          peak_q[n] <= res[n];
        end else if (peak_clr[n]) begin
          peak_q[n] <= '0;
        end
      end
      if (iWriteValid && wa == ADDR_CTRL) begin
        ctrl_en <= iWriteData[0];
      end
      if (iWriteValid && wa == ADDR_ALARM_EN) begin
        alarm_en <= iWriteData[NUM_CH-1:0];
      end
      alarm_sts <= (alarm_sts & ~sts_clr) | alarm_set;
      oIrq      <= |(alarm_sts & alarm_en);
    end
  end

  always_comb begin
    rd_mux = '0;
    if (ra < CH_SPAN) begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (ra[7:4] == 4'(n)) begin
          case (ra[3:0])
            OFF_PERIOD: rd_mux = 32'(period_q[n]);
            OFF_LAST:   rd_mux = 32'(last_q[n]);
            OFF_PEAK:   rd_mux = 32'(peak_q[n]);
            OFF_THRESH: rd_mux = 32'(thresh_q[n]);
            default:    rd_mux = '0;
          endcase
        end
      end
    end else begin
      case (ra)
        ADDR_CTRL:      rd_mux = {31'd0, ctrl_en};
        ADDR_ALARM_STS: rd_mux = 32'(alarm_sts);
        ADDR_ALARM_EN:  rd_mux = 32'(alarm_en);
        default:        rd_mux = '0;
      endcase
    end
  end

  // Ack alternates so a held request is answered every second cycle.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      oReadData <= '0;
      oReadAck  <= 1'b0;
    end else if (iReadValid && !oReadAck) begin
      oReadData <= rd_mux;
      oReadAck  <= 1'b1;
    end else begin
      oReadAck  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_idle_time_monitor.sv
// Bench for idle_time_monitor: directed scenarios plus randomized windows against a cycle-count model.
module tb_idle_time_monitor;

  localparam logic [7:0] INV = 8'h80;
  localparam int         M   = 70;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] waddr, wdata, raddr;
  logic        wvld, rvld;
  logic [7:0]  probe;
  logic [1:0]  probe8;
  logic        wack, rack, irq, wack8, rack8, irq8;
  logic [31:0] rdata, rdata8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  idle_time_monitor #(.NUM_CH(8), .CNT_W(32), .PROBE_INV(INV)) dut (
    .iClock(clk), .iReset(rst),
    .iWriteAddress(waddr), .iWriteData(wdata), .iWriteValid(wvld), .oWriteAck(wack),
    .iReadAddress(raddr), .oReadData(rdata), .iReadValid(rvld), .oReadAck(rack),
    .iProbe(probe), .oIrq(irq)
  );

  idle_time_monitor #(.NUM_CH(2), .CNT_W(8), .PROBE_INV(2'b00)) dut8 (
    .iClock(clk), .iReset(rst),
    .iWriteAddress(waddr), .iWriteData(wdata), .iWriteValid(wvld), .oWriteAck(wack8),
    .iReadAddress(raddr), .oReadData(rdata8), .iReadValid(rvld), .oReadAck(rack8),
    .iProbe(probe8), .oIrq(irq8)
  );

  task automatic cyc(input logic [7:0] p, input logic w, input logic [31:0] a, input logic [31:0] d);
    probe = p; wvld = w; waddr = a; wdata = d;
    @(negedge clk);
    wvld = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(probe, 1'b1, a, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Returns X when the ack is missing so the caller's data compare fails.
  task automatic rd(input logic [31:0] a, input logic sel8, output logic [31:0] d);
    raddr = a; rvld = 1'b1;
    @(negedge clk);
    if (sel8) d = rack8 ? rdata8 : 'x;
    else      d = rack  ? rdata  : 'x;
    rvld = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; wvld = 1'b0; rvld = 1'b0; probe = '0; probe8 = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic read_all_zero(input string tag);
    logic [31:0] d;
    for (int c = 0; c < 8; c++) begin
      for (int o = 0; o < 16; o += 4) begin
        rd(32'(c * 16 + o), 1'b0, d);
        checks++;
        if (d !== 32'd0) begin
          errors++;
          $display("FAIL %s addr=%h got %h expected 0", tag, c * 16 + o, d);
        end
      end
    end
    for (int g = 0; g < 3; g++) begin
      rd(32'h100 + 32'(g * 4), 1'b0, d);
      checks++;
      if (d !== 32'd0) begin
        errors++;
        $display("FAIL %s addr=%h got %h expected 0", tag, 32'h100 + g * 4, d);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    checks++;
    if ({irq, rack, rdata} !== 34'd0 || wack !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs irq=%b ack=%b data=%h wack=%b expected 0,0,0,1", irq, rack, rdata, wack);
    end
    rst = 1'b0;
    read_all_zero("reset_reg");
  endtask

  task automatic test_const_idle();
    logic [31:0] d;
    do_reset();
    wr(32'h0, 32'd10);
    probe = 8'h01;
    wr(32'h100, 32'd1);
    idle(9);
    rd(32'h4, 1'b0, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL last0_early got %h expected 0", d); end
    rd(32'h4, 1'b0, d);
    checks++;
    if (d !== 32'd10) begin errors++; $display("FAIL last0 got %h expected 10", d); end
    rd(32'h8, 1'b0, d);
    checks++;
    if (d !== 32'd10) begin errors++; $display("FAIL peak0 got %h expected 10", d); end
  endtask

  task automatic test_alarm();
    logic [31:0] d;
    do_reset();
    wr(32'h10, 32'd8);
    wr(32'h1C, 32'd2);
    wr(32'h108, 32'h2);
    probe = 8'h00;
    wr(32'h100, 32'd1);
    for (int k = 0; k < 8; k++) cyc((k < 3) ? 8'h02 : 8'h00, 1'b0, 32'h0, 32'h0);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_early got %b expected 0", irq); end
    idle(1);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got %b expected 1", irq); end
    rd(32'h14, 1'b0, d);
    checks++;
    if (d !== 32'd3) begin errors++; $display("FAIL last1 got %h expected 3", d); end
    rd(32'h104, 1'b0, d);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL alarm_sts got %h expected 2", d); end
    wr(32'h104, 32'h2);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold got %b expected 1", irq); end
    idle(1);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_w1c got %b expected 0", irq); end
    rd(32'h104, 1'b0, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL alarm_w1c got %h expected 0", d); end
  endtask

  task automatic test_collisions();
    logic [31:0] d;
    do_reset();
    wr(32'h20, 32'd8);
    wr(32'h2C, 32'd6);
    probe = 8'h00;
    wr(32'h100, 32'd1);
    for (int k = 0; k < 16; k++)
      cyc((k < 13) ? 8'h04 : 8'h00, (k == 7 || k == 15),
          (k == 7) ? 32'h104 : 32'h28, (k == 7) ? 32'h4 : 32'h0);
    rd(32'h28, 1'b0, d);
    checks++;
    if (d !== 32'd5) begin errors++; $display("FAIL peak_clr_collide got %h expected 5", d); end
    rd(32'h24, 1'b0, d);
    checks++;
    if (d !== 32'd5) begin errors++; $display("FAIL last2 got %h expected 5", d); end
    rd(32'h104, 1'b0, d);
    checks++;
    if (d !== 32'h4) begin errors++; $display("FAIL w1c_collide got %h expected 4", d); end
    wr(32'h28, 32'h0);
    rd(32'h28, 1'b0, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL peak_clr got %h expected 0", d); end
  endtask

  task automatic test_restart_and_reset();
    logic [31:0] d;
    do_reset();
    wr(32'h30, 32'd10);
    probe = 8'h08;
    wr(32'h100, 32'd1);
    for (int k = 0; k < 14; k++) cyc(8'h08, (k == 4), 32'h30, 32'd10);
    rd(32'h34, 1'b0, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL restart_early got %h expected 0", d); end
    rd(32'h34, 1'b0, d);
    checks++;
    if (d !== 32'd10) begin errors++; $display("FAIL restart_last got %h expected 10", d); end
    wr(32'h108, 32'hFF);
    wr(32'h3C, 32'd1);
    idle(14);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_before_reset got %b expected 1", irq); end
    idle(3);
    raddr = 32'h34; rvld = 1'b1; rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({rack, irq, rdata} !== 34'd0) begin
      errors++;
      $display("FAIL reset_mid_read ack=%b irq=%b data=%h expected 0", rack, irq, rdata);
    end
    rst = 1'b0; rvld = 1'b0;
    @(negedge clk);
    checks++;
    if (rack !== 1'b0) begin errors++; $display("FAIL ack_after_reset got %b expected 0", rack); end
    read_all_zero("midwin_reset_reg");
  endtask

  task automatic test_read_protocol();
    logic [31:0] d;
    do_reset();
    wr(32'h90, 32'd5);
    rd(32'h90, 1'b0, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL oor_channel got %h expected 0", d); end
    rd(32'h200, 1'b0, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL unmapped_200 got %h expected 0", d); end
    wr(32'h0, 32'h33);
    wr(32'h4, 32'h77);
    rd(32'h1, 1'b0, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL unaligned got %h expected 0", d); end
    rd(32'h0, 1'b0, d);
    checks++;
    if (d !== 32'h33) begin errors++; $display("FAIL period_rw got %h expected 33", d); end
    rd(32'h4, 1'b0, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL last_ro got %h expected 0", d); end
    wr(32'h108, 32'h5A);
    raddr = 32'h108; rvld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (rack !== ((i % 2) == 0) || ((i % 2) == 0 && rdata !== 32'h5A)) begin
        errors++;
        $display("FAIL held_read cycle=%0d ack=%b data=%h expected ack=%b data=5a", i, rack, rdata, (i % 2) == 0);
      end
    end
    rvld = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cnt8();
    logic [31:0] d;
    do_reset();
    wr(32'h0, 32'h1FF);
    probe8 = 2'b01;
    wr(32'h100, 32'd1);
    idle(257);
    rd(32'h0, 1'b1, d);
    checks++;
    if (d !== 32'hFF) begin errors++; $display("FAIL cnt8_period got %h expected ff", d); end
    rd(32'h4, 1'b1, d);
    checks++;
    if (d !== 32'hFF) begin errors++; $display("FAIL cnt8_last got %h expected ff", d); end
    rd(32'h8, 1'b1, d);
    checks++;
    if (d !== 32'hFF) begin errors++; $display("FAIL cnt8_peak got %h expected ff", d); end
    probe8 = 2'b00;
  endtask

  task automatic test_random();
    logic [7:0]  s [0:M];
    int          per [8];
    int          thr [8];
    int          e_last [8];
    int          e_peak [8];
    logic [7:0]  e_sts;
    logic [7:0]  en;
    logic [7:0]  inv_v;
    logic [31:0] d;
    int          cnt, sum;
    inv_v = INV;
    for (int it = 0; it < 3; it++) begin
      do_reset();
      en = 8'($urandom);
      for (int c = 0; c < 8; c++) begin
        per[c] = int'($urandom_range(1, 12));
        thr[c] = int'($urandom_range(0, 6));
        wr(32'(c * 16), 32'(per[c]));
        wr(32'(c * 16 + 12), 32'(thr[c]));
      end
      wr(32'h108, 32'(en));
      probe = 8'h00;
      wr(32'h100, 32'd1);
      for (int k = 0; k <= M; k++) begin
        s[k] = 8'($urandom);
        cyc(s[k], (k == M), 32'h100, 32'h0);
      end
      e_sts = '0;
      for (int c = 0; c < 8; c++) begin
        cnt = 0; sum = 0; e_last[c] = 0; e_peak[c] = 0;
        for (int k = 0; k <= M; k++) begin
          sum += int'(s[k][c] ^ inv_v[c]);
          cnt++;
          if (cnt == per[c]) begin
            e_last[c] = sum;
            if (sum > e_peak[c]) e_peak[c] = sum;
            if (sum > thr[c]) e_sts[c] = 1'b1;
            cnt = 0; sum = 0;
          end
        end
      end
      idle(2);
      checks++;
      if (irq !== |(e_sts & en)) begin
        errors++;
        $display("FAIL rand_irq it=%0d got %b expected %b", it, irq, |(e_sts & en));
      end
      rd(32'h104, 1'b0, d);
      checks++;
      if (d !== 32'(e_sts)) begin errors++; $display("FAIL rand_sts it=%0d got %h expected %h", it, d, e_sts); end
      for (int c = 0; c < 8; c++) begin
        rd(32'(c * 16 + 4), 1'b0, d);
        checks++;
        if (d !== 32'(e_last[c])) begin
          errors++;
          $display("FAIL rand_last it=%0d ch=%0d got %0d expected %0d", it, c, d, e_last[c]);
        end
        rd(32'(c * 16 + 8), 1'b0, d);
        checks++;
        if (d !== 32'(e_peak[c])) begin
          errors++;
          $display("FAIL rand_peak it=%0d ch=%0d got %0d expected %0d", it, c, d, e_peak[c]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; wvld = 1'b0; rvld = 1'b0; probe = '0; probe8 = '0;
    waddr = '0; wdata = '0; raddr = '0;
    test_reset();
    test_const_idle();
    test_alarm();
    test_collisions();
    test_restart_and_reset();
    test_read_protocol();
    test_cnt8();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
